// File: rtl/ysyx_22050550_pkg.sv
// Shared constants for the ysyx_22050550 write-back/commit stage:
// machine-mode CSR addresses, mstatus/mie/mip bit positions, cause codes and the CSR op encoding.
package ysyx_22050550_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;
  localparam int MIP_MTIP       = 7;

  // UXL/SXL = 2 (64-bit), MPP = M-mode
  localparam logic [63:0] MSTATUS_RESET = 64'h0000_000A_0000_1800;

  localparam int CAUSE_MTIMER  = 7;
  localparam int CAUSE_ECALL_M = 11;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

endpackage

// File: rtl/ysyx_22050550_csr_file.sv
// Machine-mode CSR registers: combinational read by address, one write port, trap/mret update port.
// Updates land on the clock edge; trap updates override the generic write port.
module ysyx_22050550_csr_file
  import ysyx_22050550_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int ECALL_CAUSE = CAUSE_ECALL_M
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            irq_mtip,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_hit,
  input  logic            wr_en,
  input  logic [11:0]     wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            trap_irq,
  input  logic            trap_ecall,
  input  logic            trap_mret,
  input  logic [XLEN-1:0] trap_pc,
  output logic            irq_enable,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc
);

  logic [XLEN-1:0] mstatus_q, mtvec_q, mepc_q, mcause_q, mie_q, mip_q, mscratch_q;
  logic [XLEN-1:0] mip_rd;

  // MTIP is never stored; it is the live timer level
  always_comb begin
    mip_rd           = mip_q;
    mip_rd[MIP_MTIP] = irq_mtip;
  end

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b1;
    case (rd_addr)
      CSR_MSTATUS:  rd_data = mstatus_q;
      CSR_MIE:      rd_data = mie_q;
      CSR_MTVEC:    rd_data = mtvec_q;
      CSR_MSCRATCH: rd_data = mscratch_q;
      CSR_MEPC:     rd_data = mepc_q;
      CSR_MCAUSE:   rd_data = mcause_q;
      CSR_MIP:      rd_data = mip_rd;
      default:      rd_hit  = 1'b0;
    endcase
  end

  assign irq_enable = mstatus_q[MSTATUS_MIE] & mie_q[MIE_MTIE];
  assign mtvec      = mtvec_q;
  assign mepc       = mepc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_q  <= XLEN'(MSTATUS_RESET);
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mie_q      <= '0;
      mip_q      <= '0;
      mscratch_q <= '0;
    end else if (trap_irq) begin
      mepc_q   <= trap_pc;
      mcause_q <= {1'b1, (XLEN-1)'(CAUSE_MTIMER)};
    end else if (trap_ecall) begin
      mepc_q                                   <= trap_pc;
      mcause_q                                 <= XLEN'(ECALL_CAUSE);
      mstatus_q[MSTATUS_MPIE]                  <= mstatus_q[MSTATUS_MIE];
      mstatus_q[MSTATUS_MIE]                   <= 1'b0;
      mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
    end else if (trap_mret) begin
      mstatus_q[MSTATUS_MIE]                   <= mstatus_q[MSTATUS_MPIE];
      mstatus_q[MSTATUS_MPIE]                  <= 1'b1;
      mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
    end else if (wr_en) begin
      case (wr_addr)
        CSR_MSTATUS:  mstatus_q  <= wr_data;
        CSR_MIE:      mie_q      <= wr_data;
        CSR_MTVEC:    mtvec_q    <= wr_data;
        CSR_MSCRATCH: mscratch_q <= wr_data;
        CSR_MEPC:     mepc_q     <= wr_data;
        CSR_MCAUSE:   mcause_q   <= wr_data;
        CSR_MIP:      mip_q      <= wr_data & ~(XLEN'(1) << MIP_MTIP);
        default:      ;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22050550_wbu_commit.sv
// Registered write-back/commit: CSR ops, ecall/mret/timer-irq trap priority and a one-cycle fetch redirect.
// One cycle latency; the output beat holds while wb_ready is low and in_ready = ~wb_valid | wb_ready.
module ysyx_22050550_wbu_commit
  import ysyx_22050550_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int RADDR_W     = 5,
  parameter int ECALL_CAUSE = CAUSE_ECALL_M
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [31:0]        in_inst,
  input  logic [RADDR_W-1:0] in_rs1addr,
  input  logic               in_csrflag,
  input  logic               in_ecallflag,
  input  logic               in_mretflag,
  input  logic               in_readflag,
  input  logic               in_wen,
  input  logic [2:0]         in_func3,
  input  logic [RADDR_W-1:0] in_waddr,
  input  logic [XLEN-1:0]    in_alures,
  input  logic [XLEN-1:0]    in_lsures,
  input  logic               irq_mtip,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [XLEN-1:0]    wb_pc,
  output logic [31:0]        wb_inst,
  output logic [RADDR_W-1:0] wb_waddr,
  output logic [XLEN-1:0]    wb_wdata,
  output logic               wb_wen,
  output logic               wb_trap,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [XLEN-1:0]    csr_mtvec,
  output logic [XLEN-1:0]    csr_mepc
);

  logic            fire;
  csr_op_e         op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_old, csr_new, rd_data;
  logic            csr_hit, csr_skip, csr_we;
  logic            irq_enable, take_irq, take_ecall, take_mret, take_redirect;
  logic            unused_func3;

  assign in_ready     = ~wb_valid | wb_ready;
  assign fire         = in_valid & in_ready;
  assign op           = csr_op_e'(in_func3[1:0]);
  assign csr_addr     = in_inst[31:20];
  assign unused_func3 = in_func3[2];

  // irq uses the CSR state from before this beat, so an enable written now only counts next beat
  assign take_irq      = fire & irq_enable & irq_mtip;
  assign take_ecall    = fire & ~take_irq & in_ecallflag;
  assign take_mret     = fire & ~take_irq & ~in_ecallflag & in_mretflag;
  assign take_redirect = take_irq | take_ecall | take_mret;

  assign csr_skip = ((op == CSR_SET) || (op == CSR_CLEAR)) && (in_rs1addr == '0);
  assign csr_we   = fire & ~take_irq & ~in_ecallflag & ~in_mretflag & in_csrflag
                  & (op != CSR_NONE) & ~csr_skip & csr_hit;

  always_comb begin
    csr_new = csr_old;
    case (op)
      CSR_WRITE: csr_new = in_alures;
      CSR_SET:   csr_new = csr_old | in_alures;
      CSR_CLEAR: csr_new = csr_old & ~in_alures;
      default:   csr_new = csr_old;
    endcase
  end

  assign rd_data = in_csrflag ? csr_old : (in_readflag ? in_lsures : in_alures);

  ysyx_22050550_csr_file #(
    .XLEN        (XLEN),
    .ECALL_CAUSE (ECALL_CAUSE)
  ) u_csr (
    .clock      (clock),
    .reset      (reset),
    .irq_mtip   (irq_mtip),
    .rd_addr    (csr_addr),
    .rd_data    (csr_old),
    .rd_hit     (csr_hit),
    .wr_en      (csr_we),
    .wr_addr    (csr_addr),
    .wr_data    (csr_new),
    .trap_irq   (take_irq),
    .trap_ecall (take_ecall),
    .trap_mret  (take_mret),
    .trap_pc    (in_pc),
    .irq_enable (irq_enable),
    .mtvec      (csr_mtvec),
    .mepc       (csr_mepc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid       <= 1'b0;
      wb_pc          <= '0;
      wb_inst        <= '0;
      wb_waddr       <= '0;
      wb_wdata       <= '0;
      wb_wen         <= 1'b0;
      wb_trap        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      if (fire) begin
        wb_valid       <= 1'b1;
        wb_pc          <= in_pc;
        wb_inst        <= in_inst;
        wb_waddr       <= in_waddr;
        wb_wdata       <= rd_data;
        wb_wen         <= in_wen & ~take_irq;
        wb_trap        <= take_irq;
        redirect_valid <= take_redirect;
        // mret returns to the mepc held before this edge
        if (take_redirect) redirect_pc <= take_mret ? csr_mepc : csr_mtvec;
      end else if (wb_ready) begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule
